// File: rtl/status_tx_pkg.sv
// status_tx_pkg: ASCII constants, FSM encoding and line layout shared by the status reporter
package status_tx_pkg;
  localparam logic [7:0] CH_F = 8'h46;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_P = 8'h50;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam int LINE_LEN_CRLF = 18;
  localparam int LINE_LEN_LF = 17;
  typedef enum logic [2:0] {IDLE, SNAP, CONV_F, CONV_P, SEND} state_t;
  function automatic logic [7:0] digit(input logic [3:0] d);
    return CH_0 + {4'b0, d};
  endfunction
  function automatic logic [7:0] line_byte(input logic [4:0] i, input logic [15:0] f, input logic [2:0] a,
                                           input logic [11:0] p, input logic crlf);
    case (i)
      5'd0: return CH_F;
      5'd1: return CH_EQ;
      5'd2: return digit(f[15:12]);
      5'd3: return digit(f[11:8]);
      5'd4: return digit(f[7:4]);
      5'd5: return digit(f[3:0]);
      5'd6: return CH_SP;
      5'd7: return CH_A;
      5'd8: return CH_EQ;
      5'd9: return digit({1'b0, a});
      5'd10: return CH_SP;
      5'd11: return CH_P;
      5'd12: return CH_EQ;
      5'd13: return digit(p[11:8]);
      5'd14: return digit(p[7:4]);
      5'd15: return digit(p[3:0]);
      5'd16: return crlf ? CH_CR : CH_LF;
      default: return CH_LF;
    endcase
  endfunction
endpackage

// File: rtl/status_tx_bin2bcd.sv
// bin2bcd: sequential double-dabble of a 12-bit value into four BCD digits, 13-cycle latency
module bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic [15:0] bcd,
  output logic        done
);
  logic [27:0] sh;
  logic [26:0] adj;
  logic [3:0] cnt;
  logic run;
  always_comb begin
    adj = sh[26:0];
    for (int i = 0; i < 3; i++)
      adj[12+4*i +: 4] = sh[12+4*i +: 4] >= 4'd5 ? sh[12+4*i +: 4] + 4'd3 : sh[12+4*i +: 4];
  end
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      run <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= run && cnt == 4'd1;
      if (run) begin
        sh <= {adj, 1'b0};
        cnt <= cnt - 4'd1;
        run <= cnt != 4'd1;
      end else if (start) begin
        sh <= {16'b0, bin};
        cnt <= 4'd12;
        run <= 1'b1;
      end
    end
  assign bcd = sh[27:12];
endmodule

// File: rtl/status_tx.sv
// status_tx: snapshots freq/amp/phase and streams them as an ASCII status line over valid/ready
module status_tx
  import status_tx_pkg::*;
#(
  parameter bit AUTO_REPORT = 1'b1,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] state_freq,
  input  logic [2:0]  state_amp,
  input  logic [7:0]  state_phase,
  input  logic        report_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);
  localparam logic [4:0] LAST = EOL_CRLF ? 5'(LINE_LEN_CRLF - 1) : 5'(LINE_LEN_LF - 1);
  state_t state, nxt;
  logic [11:0] last_f, p_bcd;
  logic [2:0] last_a;
  logic [7:0] last_p;
  logic [15:0] f_bcd, bcd;
  logic [4:0] idx;
  logic pending, done, trig, fin;
  assign trig = report_req || (AUTO_REPORT && {state_freq, state_amp, state_phase} != {last_f, last_a, last_p});
  assign fin = state == SEND && tx_ready && idx == LAST;
  bin2bcd u_bcd (
    .clk(clk),
    .rst(rst),
    .start(state == SNAP || (state == CONV_F && done)),
    .bin(state == SNAP ? state_freq : {4'b0, last_p}),
    .bcd(bcd),
    .done(done)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = trig ? SNAP : IDLE;
      SNAP: nxt = CONV_F;
      CONV_F: nxt = done ? CONV_P : CONV_F;
      CONV_P: nxt = done ? SEND : CONV_P;
      SEND: nxt = fin ? (pending || trig ? SNAP : IDLE) : SEND;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      last_f <= '0;
      last_a <= '0;
      last_p <= '0;
      f_bcd <= '0;
      p_bcd <= '0;
      idx <= '0;
      pending <= 1'b0;
      busy <= 1'b0;
    end else begin
      if (state == SNAP) {last_f, last_a, last_p} <= {state_freq, state_amp, state_phase};
      if (state == CONV_F && done) f_bcd <= bcd;
      if (state == CONV_P && done) p_bcd <= bcd[11:0];
      idx <= state != SEND ? '0 : idx + {4'b0, tx_ready};
      pending <= nxt == SNAP ? 1'b0 : (trig && state inside {CONV_F, CONV_P, SEND}) ? 1'b1 : pending;
      busy <= state != IDLE && nxt != IDLE;
    end
  always_comb begin
    tx_valid = state == SEND;
    tx_data = tx_valid ? line_byte(idx, f_bcd, last_a, p_bcd, EOL_CRLF) : 8'h00;
  end
endmodule

// File: tb/tb_status_tx.sv
// tb_status_tx: table, sequence and random checks of status_tx lines against a formatted-string model
module tb_status_tx;
  typedef struct {
    logic [11:0] f;
    logic [2:0] a;
    logic [7:0] p;
    logic [143:0] e_crlf;
    logic [135:0] e_lf;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, tx_ready = 1'b1;
  logic [11:0] f = '0;
  logic [2:0] a = '0;
  logic [7:0] p = '0;
  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, b0, b1, b2;
  int errors = 0, checks = 0, mode = 0, cyc = 0, stall_bad = 0;
  logic [7:0] cap0[$], cap1[$], cap2[$];
  logic prst = 1'b1, pr = 1'b0;
  logic [2:0] pv = '0;
  logic [7:0] pd[3];
  vec_t tbl[4];
  always #5 clk = ~clk;
  status_tx #(.AUTO_REPORT(1'b0), .EOL_CRLF(1'b1)) u0 (.clk(clk), .rst(rst), .state_freq(f), .state_amp(a),
    .state_phase(p), .report_req(req), .tx_data(d0), .tx_valid(v0), .tx_ready(tx_ready), .busy(b0));
  status_tx #(.AUTO_REPORT(1'b0), .EOL_CRLF(1'b0)) u1 (.clk(clk), .rst(rst), .state_freq(f), .state_amp(a),
    .state_phase(p), .report_req(req), .tx_data(d1), .tx_valid(v1), .tx_ready(tx_ready), .busy(b1));
  status_tx #(.AUTO_REPORT(1'b1), .EOL_CRLF(1'b1)) u2 (.clk(clk), .rst(rst), .state_freq(f), .state_amp(a),
    .state_phase(p), .report_req(req), .tx_data(d2), .tx_valid(v2), .tx_ready(tx_ready), .busy(b2));
  always @(negedge clk) begin
    if (!rst && tx_ready) begin
      if (v0) cap0.push_back(d0);
      if (v1) cap1.push_back(d1);
      if (v2) cap2.push_back(d2);
    end
    if (!prst && !pr && ((pv[0] && (!v0 || d0 != pd[0])) || (pv[1] && (!v1 || d1 != pd[1])) ||
        (pv[2] && (!v2 || d2 != pd[2]))))
      stall_bad <= stall_bad + 1;
    prst <= rst;
    pr <= tx_ready;
    pv <= {v2, v1, v0};
    pd[0] <= d0;
    pd[1] <= d1;
    pd[2] <= d2;
  end
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    tx_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
  end
  function automatic int qsize(input int inst);
    return inst == 0 ? cap0.size() : inst == 1 ? cap1.size() : cap2.size();
  endfunction
  function automatic logic [7:0] getb(input int inst, input int i);
    return inst == 0 ? cap0[i] : inst == 1 ? cap1[i] : cap2[i];
  endfunction
  function automatic logic [143:0] model_line(input int mf, input int ma, input int mp, input bit crlf);
    string s;
    logic [143:0] v;
    s = $sformatf("F=%04d A=%0d P=%03d", mf, ma, mp);
    s = crlf ? {s, "\015\012"} : {s, "\012"};
    v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[135:0], s[i]};
    return v;
  endfunction
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask
  task automatic chk_line(input string name, input int inst, input int base, input logic [143:0] e, input int n);
    int bad;
    bad = -1;
    checks++;
    if (qsize(inst) < base + n) begin
      errors++;
      $display("FAIL %s: only %0d bytes, want %0d", name, qsize(inst) - base, n);
    end else begin
      for (int i = 0; i < n; i++)
        if (bad < 0 && getb(inst, base + i) != e[(n-1-i)*8 +: 8]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s: byte %0d got %h want %h", name, bad, getb(inst, base + bad), e[(n-1-bad)*8 +: 8]);
      end
    end
  endtask
  task automatic wait_quiet();
    int q, t;
    q = 0;
    t = 0;
    while (q < 5 && t < 4000) begin
      step();
      t++;
      q = (b0 | b1 | b2 | v0 | v1 | v2) ? 0 : q + 1;
    end
    chk("quiet_timeout", int'(q >= 5), 1);
  endtask
  task automatic wait_bytes(input int inst, input int n);
    int t;
    t = 0;
    while (qsize(inst) < n && t < 1000) begin
      step();
      t++;
    end
    chk("bytes_timeout", int'(qsize(inst) >= n), 1);
  endtask
  initial begin
    int base0, base1, base2, k, sb;
    tbl[0] = '{12'd1, 3'd1, 8'd0, "F=0001 A=1 P=000\015\012", "F=0001 A=1 P=000\012"};
    tbl[1] = '{12'd4095, 3'd7, 8'd255, "F=4095 A=7 P=255\015\012", "F=4095 A=7 P=255\012"};
    tbl[2] = '{12'd524, 3'd3, 8'd9, "F=0524 A=3 P=009\015\012", "F=0524 A=3 P=009\012"};
    tbl[3] = '{12'd0, 3'd0, 8'd0, "F=0000 A=0 P=000\015\012", "F=0000 A=0 P=000\012"};
    step(3);
    rst = 1'b0;
    step();
    chk("reset_valid", int'(v0), 0);
    chk("reset_data", int'(d0), 0);
    chk("reset_busy", int'(b0), 0);
    chk("reset_auto_valid", int'(v2), 0);
    chk("reset_auto_busy", int'(b2), 0);
    for (int i = 0; i < 4; i++) begin
      f = tbl[i].f;
      a = tbl[i].a;
      p = tbl[i].p;
      base0 = qsize(0);
      base1 = qsize(1);
      pulse();
      if (i == 0) begin
        chk("busy_in_snap", int'(b0), 0);
        k = 0;
        while (!v0 && k < 40) begin
          step();
          k++;
          if (k == 1) chk("busy_after_snap", int'(b0), 1);
        end
        chk("first_valid_latency", k, 27);
      end
      wait_quiet();
      chk_line($sformatf("tbl%0d_crlf", i), 0, base0, tbl[i].e_crlf, 18);
      chk_line($sformatf("tbl%0d_lf", i), 1, base1, {8'h00, tbl[i].e_lf}, 17);
      chk($sformatf("tbl%0d_len_crlf", i), qsize(0) - base0, 18);
      chk($sformatf("tbl%0d_len_lf", i), qsize(1) - base1, 17);
    end
    mode = 1;
    sb = stall_bad;
    f = 12'd1;
    a = 3'd1;
    p = 8'd0;
    base0 = qsize(0);
    pulse();
    wait_quiet();
    chk_line("stall_line", 0, base0, model_line(1, 1, 0, 1'b1), 18);
    chk("stall_len", qsize(0) - base0, 18);
    chk("stall_stable", stall_bad - sb, 0);
    f = 12'd524;
    a = 3'd2;
    p = 8'd77;
    base0 = qsize(0);
    pulse();
    wait_bytes(0, base0 + 3);
    pulse();
    step(4);
    f = 12'd100;
    pulse();
    step(4);
    pulse();
    wait_quiet();
    chk_line("pending_first", 0, base0, model_line(524, 2, 77, 1'b1), 18);
    chk_line("pending_follow", 0, base0 + 18, model_line(100, 2, 77, 1'b1), 18);
    chk("pending_len", qsize(0) - base0, 36);
    mode = 2;
    sb = stall_bad;
    for (int i = 0; i < 6; i++) begin
      f = 12'($urandom_range(0, 4095));
      a = 3'($urandom_range(0, 7));
      p = 8'($urandom_range(0, 255));
      base0 = qsize(0);
      base1 = qsize(1);
      pulse();
      wait_quiet();
      chk_line($sformatf("rand%0d_crlf", i), 0, base0, model_line(int'(f), int'(a), int'(p), 1'b1), 18);
      chk_line($sformatf("rand%0d_lf", i), 1, base1, model_line(int'(f), int'(a), int'(p), 1'b0), 17);
      chk($sformatf("rand%0d_len", i), qsize(0) - base0, 18);
    end
    chk("rand_stall_stable", stall_bad - sb, 0);
    mode = 0;
    f = 12'd321;
    a = 3'd4;
    p = 8'd12;
    base0 = qsize(0);
    pulse();
    wait_bytes(0, base0 + 5);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", int'(v0), 0);
    chk("rst_mid_busy", int'(b0), 0);
    rst = 1'b0;
    step();
    chk("rst_partial_bytes", qsize(0) - base0, 5);
    base0 = qsize(0);
    pulse();
    wait_quiet();
    chk_line("rst_restart_line", 0, base0, model_line(321, 4, 12, 1'b1), 18);
    chk("rst_restart_len", qsize(0) - base0, 18);
    rst = 1'b1;
    f = '0;
    a = '0;
    p = '0;
    step(3);
    rst = 1'b0;
    step(2);
    base2 = qsize(2);
    f = 12'd1;
    a = 3'(50 % 8);
    p = 8'd50;
    wait_quiet();
    chk_line("auto_first", 2, base2, model_line(1, 50 % 8, 50, 1'b1), 18);
    step(200);
    chk("auto_hold", qsize(2) - base2, 18);
    f = 12'd1000;
    wait_quiet();
    chk_line("auto_freq1000", 2, base2 + 18, model_line(1000, 2, 50, 1'b1), 18);
    chk("auto_freq1000_len", qsize(2) - base2, 36);
    mode = 1;
    base2 = qsize(2);
    f = 12'd2000;
    wait_bytes(2, base2 + 2);
    f = 12'd2001;
    step(3);
    a = 3'd5;
    wait_quiet();
    chk_line("auto_mid_first", 2, base2, model_line(2000, 2, 50, 1'b1), 18);
    chk_line("auto_mid_follow", 2, base2 + 18, model_line(2001, 5, 50, 1'b1), 18);
    chk("auto_mid_len", qsize(2) - base2, 36);
    mode = 0;
    base2 = qsize(2);
    f = 12'd7;
    pulse();
    wait_quiet();
    chk_line("auto_req_same_cycle", 2, base2, model_line(7, 5, 50, 1'b1), 18);
    chk("auto_req_same_cycle_len", qsize(2) - base2, 18);
    mode = 2;
    for (int i = 0; i < 4; i++) begin
      base2 = qsize(2);
      f = 12'($urandom_range(0, 4095));
      p = 8'($urandom_range(0, 255));
      wait_quiet();
      chk_line($sformatf("auto_rand%0d", i), 2, base2, model_line(int'(f), int'(a), int'(p), 1'b1), 18);
      chk($sformatf("auto_rand%0d_len", i), qsize(2) - base2, 18);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/status_tx.md
Name: status_tx

Overview:
- Reporting side of the command path: the command decoder turns received UART bytes into freq/amp/phase state; status_tx turns that state back into an ASCII status line for the UART transmitter.
- Snapshots state_freq/state_amp/state_phase on a request, or on a change when auto-report is enabled.
- Converts the snapshot to decimal and streams the line one byte at a time over a valid/ready interface into the UART TX byte port.

Parameters:
- AUTO_REPORT, 1: when 1, any change of the inputs versus the last reported snapshot triggers a report.
- EOL_CRLF, 1: when 1, line ends CR LF (18 bytes); when 0, line ends LF only (17 bytes).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous reset, active-high
- state_freq  input  12  current frequency setting
- state_amp  input  3  current amplitude setting
- state_phase  input  8  current phase setting
- report_req  input  1  single-cycle request for a status line
- tx_data  output  8  ASCII byte to UART TX
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART TX accepts a byte this cycle
- busy  output  1  report in progress (snapshot through last byte)

Behaviour:
- Line format: "F=dddd A=d P=ddd" then EOL.
  - Leading zeros kept; freq is 4 digits (0..4095), amp is 1 digit ('0'+amp), phase is 3 digits (0..255).
  - Bytes: 'F' '=' d3 d2 d1 d0 ' ' 'A' '=' a ' ' 'P' '=' p2 p1 p0, then 0x0D 0x0A (or 0x0A only).
- Reset: tx_valid=0, tx_data=0, busy=0, FSM=IDLE, pending=0, last-reported registers=0.
- Trigger: report_req=1, or (AUTO_REPORT=1 and {freq,amp,phase} != last-reported).
- FSM states: IDLE -> SNAP -> CONV_F -> CONV_P -> SEND -> IDLE.
  - IDLE: trigger at edge n moves to SNAP.
  - SNAP: inputs latched into the snapshot and last-reported registers; busy=1 from edge n+1.
  - CONV_F: bin2bcd runs on snapshot freq. Start pulse, then 12 shift/add-3 cycles; done pulse on the 13th cycle.
  - CONV_P: same bin2bcd instance run on snapshot phase, zero-extended to 12 bits.
  - SEND: byte index 0..N-1. tx_valid=1 and tx_data=byte[index].
    - On tx_valid&tx_ready the index increments.
    - tx_data must not change while tx_valid&!tx_ready.
    - tx_valid is never deasserted mid-line except on rst.
    - After the last byte is accepted, go to IDLE (busy=0 next cycle), or to SNAP if pending=1.
- First tx_valid occurs no later than 30 cycles after the trigger edge. The exact count is fixed by the implementation and documented in the test bench.
- Triggers while busy set pending; multiple triggers collapse into one. pending is cleared on entry to SNAP.
- Values are taken from the snapshot. Input changes during a report do not alter the line in progress; with AUTO_REPORT=1 they produce exactly one follow-up report.
- report_req and an auto change in the same cycle count as one trigger.
- rst mid-report: tx_valid drops at that edge, index returns to 0, pending and conversion are abandoned. No partial-line resume.
- tx_ready while tx_valid=0 is ignored.

Decomposition:
- Shared package:
  - ASCII constants: CH_F, CH_A, CH_P, CH_EQ, CH_SP, CH_CR, CH_LF, CH_0.
  - FSM state encoding.
  - Line-length constants LINE_LEN_CRLF=18, LINE_LEN_LF=17.
- Sub-module bin2bcd.
  - Ports: clk, rst, start, bin[11:0], bcd[15:0], done.
  - Sequential double-dabble, latency 13 cycles, done is a 1-cycle pulse.
  - Ignores start while running.

Test Plan:
- AUTO_REPORT=0, freq=1 amp=1 phase=0, tx_ready=1, pulse report_req -> exactly 18 bytes "F=0001 A=1 P=000\r\n"; busy low after the last byte.
- freq=4095 amp=7 phase=255, report_req -> "F=4095 A=7 P=255\r\n". Repeat with EOL_CRLF=0 -> 17 bytes ending 0x0A.
- Same as first scenario but tx_ready high only every 3rd cycle -> identical byte sequence; tx_data stable throughout every valid&!ready stall; no dropped or duplicated byte.
- report_req pulsed 3 times during a line, and freq changed 524->100 mid-line -> current line keeps freq 0524; exactly one further line follows, with "F=0100".
- AUTO_REPORT=1:
  - After reset, inputs 1/50mod8/50 -> one automatic line.
  - Inputs held constant for 200 cycles -> no further lines.
  - Set freq to 1000 -> one line "F=1000 ...".
- Assert rst after 5 bytes accepted -> tx_valid=0 and busy=0 on the following cycle. The next report_req produces a full line starting at 'F'.
